// File: rtl/input_periph_dbnc.sv
// Memory-mapped switch/button input block: per-bit synchroniser and debouncer,
// sticky W1C button press events, maskable level interrupt, registered loads.

module input_periph_dbnc_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic dbnc,
    output logic dbnc_nxt
);
    localparam int CW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   diff;
    logic                   flip;

    assign diff = sync[SYNC_STAGES-1] != dbnc;
    assign flip = diff && (cnt == CNT_LAST);

    // The debounced register lives in the parent so button edges can be seen there.
    always_comb begin
        dbnc_nxt = dbnc;
        if (flip)
            dbnc_nxt = sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (!diff || flip)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module input_periph_dbnc #(
    parameter int                 ADDR_W      = 16,
    parameter int                 SW_W        = 32,
    parameter int                 BTN_W       = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 DBNC_CYCLES = 16,
    parameter logic [ADDR_W-1:0]  SW_BASE     = 'h7800,
    parameter logic [ADDR_W-1:0]  BTN_BASE    = 'h7810
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [31:0]       i_wr_data,
    input  logic [SW_W-1:0]   i_io_sw,
    input  logic [BTN_W-1:0]  i_io_btn,
    output logic [31:0]       o_ld_data,
    output logic              o_ld_valid,
    output logic              o_btn_irq
);
    localparam int N = SW_W + BTN_W;

    logic [N-1:0]      raw_all;
    logic [N-1:0]      dbnc_all;
    logic [N-1:0]      nxt_all;
    logic [SW_W-1:0]   dbnc_sw;
    logic [BTN_W-1:0]  dbnc_btn;
    logic [BTN_W-1:0]  nxt_btn;
    logic [BTN_W-1:0]  evt;
    logic [BTN_W-1:0]  mask;
    logic [BTN_W-1:0]  evt_set;
    logic [BTN_W-1:0]  evt_clr;
    logic [ADDR_W-1:0] sw_off;
    logic [ADDR_W-1:0] btn_off;
    logic              sw_hit;
    logic              btn_hit;
    logic              mask_we;
    logic [31:0]       rd_data;
    logic              unused_wr_bits;

    assign raw_all  = {i_io_btn, i_io_sw};
    assign dbnc_sw  = dbnc_all[SW_W-1:0];
    assign dbnc_btn = dbnc_all[N-1:SW_W];
    assign nxt_btn  = nxt_all[N-1:SW_W];

    for (genvar g = 0; g < N; g++) begin : g_bit
        input_periph_dbnc_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_CYCLES (DBNC_CYCLES)
        ) u_bit (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .raw      (raw_all[g]),
            .dbnc     (dbnc_all[g]),
            .dbnc_nxt (nxt_all[g])
        );
    end

    // 16-byte windows: upper offset bits must be zero (wraps below base too).
    assign sw_off  = i_addr - SW_BASE;
    assign btn_off = i_addr - BTN_BASE;
    assign sw_hit  = sw_off[ADDR_W-1:4] == '0;
    assign btn_hit = btn_off[ADDR_W-1:4] == '0;

    assign evt_set = nxt_btn & ~dbnc_btn;
    assign evt_clr = (i_wr_en && btn_hit && btn_off[3:0] == 4'h4) ? i_wr_data[BTN_W-1:0] : '0;
    assign mask_we = i_wr_en && btn_hit && btn_off[3:0] == 4'h8;
    assign unused_wr_bits = &{1'b0, i_wr_data};

    always_comb begin
        rd_data = '0;
        if (sw_hit) begin
            if (sw_off[3:0] == 4'h0)
                rd_data[SW_W-1:0] = dbnc_sw;
        end else if (btn_hit) begin
            case (btn_off[3:0])
                4'h0:    rd_data[BTN_W-1:0] = dbnc_btn;
                4'h4:    rd_data[BTN_W-1:0] = evt;
                4'h8:    rd_data[BTN_W-1:0] = mask;
                default: ;
            endcase
        end
    end

    // Set beats clear on the same bit; reads see pre-write state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dbnc_all   <= '0;
            evt        <= '0;
            mask       <= '0;
            o_ld_data  <= '0;
            o_ld_valid <= 1'b0;
            o_btn_irq  <= 1'b0;
        end else begin
            dbnc_all   <= nxt_all;
            evt        <= (evt & ~evt_clr) | evt_set;
            if (mask_we)
                mask <= i_wr_data[BTN_W-1:0];
            o_ld_valid <= i_rd_en;
            if (i_rd_en)
                o_ld_data <= rd_data;
            o_btn_irq  <= |(evt & mask);
        end
    end
endmodule

// File: tb/tb_input_periph_dbnc.sv
// Randomised and directed checks of input_periph_dbnc against a window-based
// reference model (a bit flips once its last DBNC_CYCLES synced samples all differ).

module tb_input_periph_dbnc;
    localparam int SW_W  = 32;
    localparam int BTN_W = 4;
    localparam int SYNC  = 2;
    localparam int DBNC  = 16;
    localparam int N     = SW_W + BTN_W;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [15:0]       i_addr;
    logic              i_rd_en;
    logic              i_wr_en;
    logic [31:0]       i_wr_data;
    logic [SW_W-1:0]   i_io_sw;
    logic [BTN_W-1:0]  i_io_btn;
    logic [31:0]       o_ld_data;
    logic              o_ld_valid;
    logic              o_btn_irq;

    always #5 i_clk = ~i_clk;

    input_periph_dbnc #(
        .ADDR_W (16), .SW_W (SW_W), .BTN_W (BTN_W),
        .SYNC_STAGES (SYNC), .DBNC_CYCLES (DBNC),
        .SW_BASE (16'h7800), .BTN_BASE (16'h7810)
    ) dut (
        .i_clk (i_clk), .i_rst_n (i_rst_n), .i_addr (i_addr),
        .i_rd_en (i_rd_en), .i_wr_en (i_wr_en), .i_wr_data (i_wr_data),
        .i_io_sw (i_io_sw), .i_io_btn (i_io_btn),
        .o_ld_data (o_ld_data), .o_ld_valid (o_ld_valid), .o_btn_irq (o_btn_irq)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [N-1:0]     m_rawq[$];
    logic [N-1:0]     m_syncq[$];
    logic [N-1:0]     m_dbnc;
    logic [BTN_W-1:0] m_evt, m_mask;
    logic [31:0]      m_ld_data;
    logic             m_ld_valid, m_irq;

    task automatic m_clear();
        m_rawq = {};
        repeat (SYNC) m_rawq.push_back('0);
        m_syncq = {};
        m_dbnc = '0; m_evt = '0; m_mask = '0;
        m_ld_data = '0; m_ld_valid = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a)
            16'h7800: return m_dbnc[SW_W-1:0];
            16'h7810: return 32'(m_dbnc[N-1:SW_W]);
            16'h7814: return 32'(m_evt);
            16'h7818: return 32'(m_mask);
            default:  return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic [N-1:0]     s, nd;
        logic [BTN_W-1:0] rise, clr;
        bit               all_diff;
        if (!i_rst_n) begin
            m_clear();
            return;
        end
        if (i_rd_en) m_ld_data = m_read(i_addr);
        m_ld_valid = i_rd_en;
        m_irq = |(m_evt & m_mask);
        s = m_rawq.pop_front();
        m_rawq.push_back({i_io_btn, i_io_sw});
        m_syncq.push_back(s);
        if (m_syncq.size() > DBNC) void'(m_syncq.pop_front());
        nd = m_dbnc;
        if (m_syncq.size() == DBNC) begin
            for (int b = 0; b < N; b++) begin
                all_diff = 1'b1;
                foreach (m_syncq[k]) if (m_syncq[k][b] == m_dbnc[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_dbnc[b];
            end
        end
        rise = nd[N-1:SW_W] & ~m_dbnc[N-1:SW_W];
        clr  = (i_wr_en && i_addr == 16'h7814) ? i_wr_data[BTN_W-1:0] : '0;
        if (i_wr_en && i_addr == 16'h7818) m_mask = i_wr_data[BTN_W-1:0];
        m_evt  = (m_evt & ~clr) | rise;
        m_dbnc = nd;
    endtask

    task automatic tick();
        @(posedge i_clk);
        m_step();
        @(negedge i_clk);
        chk("ld_valid", 32'(o_ld_valid), 32'(m_ld_valid));
        chk("ld_data", o_ld_data, m_ld_data);
        chk("btn_irq", 32'(o_btn_irq), 32'(m_irq));
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        i_addr = a; i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        d = o_ld_data;
        chk("rd_valid_pulse", 32'(o_ld_valid), 32'h1);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] v);
        i_addr = a; i_wr_en = 1'b1; i_wr_data = v;
        tick();
        i_wr_en = 1'b0;
    endtask

    logic [15:0] addrs[10] = '{16'h7800, 16'h7804, 16'h7810, 16'h7814, 16'h7818,
                               16'h781C, 16'h7820, 16'h780C, 16'h0000, 16'hFFFF};

    initial begin
        logic [31:0] d;
        m_clear();
        i_rst_n = 1'b0; i_addr = '0; i_rd_en = 1'b0; i_wr_en = 1'b0;
        i_wr_data = '0; i_io_sw = '0; i_io_btn = '0;
        tick(); tick();
        chk("rst_ld_data", o_ld_data, 32'h0);
        chk("rst_ld_valid", 32'(o_ld_valid), 32'h0);
        chk("rst_irq", 32'(o_btn_irq), 32'h0);
        i_rst_n = 1'b1;

        // Switch read after settling
        i_io_sw = 32'hA5A5_0F0F;
        repeat (20) tick();
        rd(16'h7800, d);
        chk("sw_read", d, 32'hA5A5_0F0F);

        // Short glitch on btn[2] must not register
        wr(16'h7818, 32'hF);
        i_io_btn = 4'b0100;
        repeat (10) tick();
        i_io_btn = 4'b0000;
        repeat (25) tick();
        rd(16'h7810, d); chk("glitch_dbnc", d, 32'h0);
        rd(16'h7814, d); chk("glitch_evt", d, 32'h0);
        chk("glitch_irq", 32'(o_btn_irq), 32'h0);

        // Held btn[1]: event at edge 18, interrupt at edge 19
        wr(16'h7818, 32'h2);
        i_io_btn = 4'b0010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 18 || k == 19) chk($sformatf("hold_irq_k%0d", k), 32'(o_btn_irq), (k >= 19) ? 32'h1 : 32'h0);
        end
        rd(16'h7814, d); chk("hold_evt", d, 32'h2);
        rd(16'h7810, d); chk("hold_dbnc", d, 32'h2);

        // W1C clears evt; interrupt follows one cycle later
        i_addr = 16'h7814; i_wr_en = 1'b1; i_wr_data = 32'h2;
        tick();
        i_wr_en = 1'b0;
        chk("w1c_irq_lag", 32'(o_btn_irq), 32'h1);
        tick();
        chk("w1c_irq_drop", 32'(o_btn_irq), 32'h0);
        rd(16'h7814, d); chk("w1c_evt", d, 32'h0);

        // New press landing in the W1C cycle: set wins
        i_io_btn = 4'b0000;
        repeat (25) tick();
        i_io_btn = 4'b0010;
        repeat (17) tick();
        wr(16'h7814, 32'h2);
        rd(16'h7814, d); chk("collide_evt", d, 32'h2);

        // Out-of-window and unlisted offsets
        rd(16'h7820, d); chk("oow_7820", d, 32'h0);
        rd(16'h780C, d); chk("unlisted_780C", d, 32'h0);

        // Reset mid-debounce (and mid-read) discards the partial count
        i_io_btn = 4'b0011;
        repeat (8) tick();
        i_rst_n = 1'b0; i_addr = 16'h7800; i_rd_en = 1'b1;
        tick();
        i_rst_n = 1'b1; i_rd_en = 1'b0;
        chk("rst_mid_valid", 32'(o_ld_valid), 32'h0);
        chk("rst_mid_data", o_ld_data, 32'h0);
        chk("rst_mid_irq", 32'(o_btn_irq), 32'h0);
        wr(16'h7818, 32'h1);
        for (int k = 2; k <= 20; k++) begin
            tick();
            if (k >= 17) chk($sformatf("restart_irq_k%0d", k), 32'(o_btn_irq), (k >= 19) ? 32'h1 : 32'h0);
        end

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) i_io_sw[$urandom_range(0, SW_W-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0)  i_io_btn[$urandom_range(0, BTN_W-1)] ^= 1'b1;
            i_rst_n   = ($urandom_range(0, 799) != 0);
            i_rd_en   = $urandom_range(0, 1) == 1;
            i_wr_en   = $urandom_range(0, 3) == 0;
            i_addr    = addrs[$urandom_range(0, 9)];
            i_wr_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
